// File: rtl/ddr3_stub_pkg.sv
// ddr3_stub_pkg
//   Shared types and constants for the DDR3 user-port stand-in.
//   - DATA_W    : user data width (16-bit words)
//   - state_e   : user-port sequencer states
//   - cnt_width : width of the latency down-counter, sized from the
//                 largest latency parameter
package ddr3_stub_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        READ,
        REFRESH
    } state_e;

    // The counter is loaded with (latency - 1) at most, so clog2 of the
    // largest latency is enough bits. Never returns less than 1.
    function automatic int cnt_width(input int rd_lat, input int wr_lat,
                                     input int ref_cycles, input int init_cycles);
        int m;
        m = rd_lat;
        if (wr_lat > m)      m = wr_lat;
        if (ref_cycles > m)  m = ref_cycles;
        if (init_cycles > m) m = init_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/stub_ram.sv
// stub_ram
//   Single-port 2^AW x DW block RAM: synchronous write, registered
//   synchronous read. Maps onto GW2A BSRAM.
//   Ports:
//     clk   in   clock, rising edge
//     en    in   port enable (read or write this edge)
//     we    in   write enable (with en); otherwise en performs a read
//     addr  in   word address
//     wdata in   write data
//     rdata out  registered read data; holds until the next read
module stub_ram
    import ddr3_stub_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    // NOTE: the array and its output register have no reset; a reset
    // term would stop the tools from mapping this onto block RAM.
    // NOTE: non-blocking assignments in clocked blocks so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ddr3_user_stub.sv
// ddr3_user_stub
//   Block-RAM stand-in for the DDR3 controller user port. Same
//   rd/wr/refresh/busy/data_ready handshake, fixed latencies.
//   Ports:
//     pclk       in   user clock, rising edge
//     resetn     in   asynchronous active-low reset
//     addr       in   word address, sampled at accept (upper bits alias)
//     rd/wr      in   read / write request
//     refresh    in   refresh request
//     din        in   write data, sampled at accept
//     dout       out  read data, held until the next read completes
//     data_ready out  one-cycle pulse, dout valid
//     busy       out  high: no command accepted
//     cmd_err    out  sticky protocol-violation flag (reset clears)
module ddr3_user_stub
    import ddr3_stub_pkg::*;
#(
    parameter int ADDR_WIDTH  = 26,
    parameter int MEM_AW      = 12,
    parameter int RD_LAT      = 6,
    parameter int WR_LAT      = 2,
    parameter int REF_CYCLES  = 8,
    parameter int INIT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rd,
    input  logic                  wr,
    input  logic                  refresh,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  data_ready,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int CW = cnt_width(RD_LAT, WR_LAT, REF_CYCLES, INIT_CYCLES);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              data_ready_q, data_ready_d;
    logic              cmd_err_q, cmd_err_d;

    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    logic [1:0]        n_req;
    logic              any_req;
    logic              multi_req;

    assign n_req     = {1'b0, rd} + {1'b0, wr} + {1'b0, refresh};
    assign any_req   = (n_req != 2'd0);
    assign multi_req = (n_req > 2'd1);

    // Upper address bits only alias; they are deliberately dropped.
    generate
        if (ADDR_WIDTH > MEM_AW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_WIDTH-1:MEM_AW];
        end
    endgenerate

    stub_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (pclk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr[MEM_AW-1:0]),
        .wdata (din),
        .rdata (ram_rdata)
    );

    // Every timed state counts down from (cycles - 1) and leaves on zero,
    // so a state loaded with N exits at the N-th edge after entry.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path leaves one unassigned and infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        dout_d       = dout_q;
        data_ready_d = 1'b0;
        cmd_err_d    = cmd_err_q;
        ram_en       = 1'b0;
        ram_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (multi_req) begin
                    cmd_err_d = 1'b1;
                end
                if (refresh) begin
                    state_d = REFRESH;
                    cnt_d   = CW'(REF_CYCLES - 1);
                end else if (wr) begin
                    state_d = WRITE;
                    cnt_d   = CW'(WR_LAT - 1);
                    ram_en  = 1'b1;
                    ram_we  = 1'b1;
                end else if (rd) begin
                    state_d = READ;
                    cnt_d   = CW'(RD_LAT - 1);
                    ram_en  = 1'b1;
                end
            end

            INIT, WRITE, REFRESH: begin
                if (any_req) begin
                    cmd_err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            READ: begin
                if (any_req) begin
                    cmd_err_d = 1'b1;
                end
                // RAM output register is valid in the first READ cycle.
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    word_d = ram_rdata;
                end
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    dout_d       = word_q;
                    data_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: begin
                state_d = INIT;
                cnt_d   = CW'(INIT_CYCLES - 1);
            end
        endcase
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= INIT;
            cnt_q        <= CW'(INIT_CYCLES - 1);
            word_q       <= '0;
            dout_q       <= '0;
            data_ready_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            dout_q       <= dout_d;
            data_ready_q <= data_ready_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;
    assign data_ready = data_ready_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_ddr3_user_stub.sv
// tb_ddr3_user_stub
//   Directed bench for ddr3_user_stub. RAM depth is raised to 2^16 so the
//   test addresses 1000, f0000 and f0008 land on distinct words while
//   1001000 still aliases onto 0001000.
module tb_ddr3_user_stub;

    localparam int ADDR_WIDTH  = 26;
    localparam int MEM_AW      = 16;
    localparam int RD_LAT      = 6;
    localparam int WR_LAT      = 2;
    localparam int REF_CYCLES  = 8;
    localparam int INIT_CYCLES = 16;

    logic                  pclk    = 1'b0;
    logic                  resetn  = 1'b0;
    logic [ADDR_WIDTH-1:0] addr    = '0;
    logic                  rd      = 1'b0;
    logic                  wr      = 1'b0;
    logic                  refresh = 1'b0;
    logic [15:0]           din     = '0;
    logic [15:0]           dout;
    logic                  data_ready;
    logic                  busy;
    logic                  cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    ddr3_user_stub #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MEM_AW      (MEM_AW),
        .RD_LAT      (RD_LAT),
        .WR_LAT      (WR_LAT),
        .REF_CYCLES  (REF_CYCLES),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .pclk       (pclk),
        .resetn     (resetn),
        .addr       (addr),
        .rd         (rd),
        .wr         (wr),
        .refresh    (refresh),
        .din        (din),
        .dout       (dout),
        .data_ready (data_ready),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    // ---------------------------------------------------------------
    // Stimulus helpers (no comparisons except the idle timeout)
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_idle(input string who);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 64) begin
            tick();
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_timeout: busy=%b expected 0", who, busy);
        end
    endtask

    task automatic issue_write(input logic [ADDR_WIDTH-1:0] a, input logic [15:0] d,
                               output int acc_cyc);
        wait_idle("issue_write");
        addr = a;
        din  = d;
        wr   = 1'b1;
        tick();
        wr      = 1'b0;
        acc_cyc = cyc;
    endtask

    // Returns edges from accept to the data_ready sample (20 = never seen).
    task automatic do_read(input logic [ADDR_WIDTH-1:0] a, output int lat,
                           output logic [15:0] data, output logic busy_at_dr);
        wait_idle("do_read");
        addr = a;
        rd   = 1'b1;
        tick();
        rd  = 1'b0;
        lat = 0;
        while (data_ready !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        data       = dout;
        busy_at_dr = busy;
    endtask

    // ---------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------
    task automatic test_reset();
        logic exp_busy;
        resetn = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({busy, data_ready, cmd_err, dout} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b dr=%b err=%b dout=%h expected 1 0 0 0000",
                     busy, data_ready, cmd_err, dout);
        end
        resetn = 1'b1;
        for (int i = 1; i <= INIT_CYCLES; i++) begin
            tick();
            exp_busy = (i < INIT_CYCLES);
            n_checks++;
            if ({busy, data_ready, cmd_err, dout} !== {exp_busy, 1'b0, 1'b0, 16'h0000}) begin
                n_fail++;
                $display("FAIL init_edge%0d: busy=%b dr=%b err=%b dout=%h expected %b 0 0 0000",
                         i, busy, data_ready, cmd_err, dout, exp_busy);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [ADDR_WIDTH-1:0] r_addr [4];
        logic [15:0]           r_exp  [4];
        int                    acc, lat;
        logic [15:0]           data;
        logic                  b;

        // First write: busy profile across E0..E2.
        issue_write(26'h1000, 16'h1234, acc);
        for (int e = 0; e <= WR_LAT; e++) begin
            if (e > 0) tick();
            n_checks++;
            if (busy !== (e < WR_LAT)) begin
                n_fail++;
                $display("FAIL write_busy_E%0d: busy=%b expected %b", e, busy, (e < WR_LAT));
            end
        end
        issue_write(26'h1001,  16'h5678, acc);
        issue_write(26'hf0000, 16'h8765, acc);
        issue_write(26'hf0008, 16'habcd, acc);

        r_addr = '{26'h1000, 26'h1001, 26'hf0008, 26'hf0000};
        r_exp  = '{16'h1234, 16'h5678, 16'habcd, 16'h8765};
        for (int i = 0; i < 4; i++) begin
            do_read(r_addr[i], lat, data, b);
            n_checks++;
            if (lat != RD_LAT || data !== r_exp[i] || b !== 1'b0) begin
                n_fail++;
                $display("FAIL read_%h: lat=%0d dout=%h busy=%b expected lat=%0d dout=%h busy=0",
                         r_addr[i], lat, data, b, RD_LAT, r_exp[i]);
            end
            tick();
            n_checks++;
            if (data_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL read_%h_pulse: data_ready=%b expected 0 one cycle later",
                         r_addr[i], data_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          a0, a1, c0, lat;
        logic [15:0] data;
        logic        b;

        issue_write(26'h1002, 16'h0102, a0);
        issue_write(26'h1003, 16'h0304, a1);
        n_checks++;
        if (a1 - a0 != WR_LAT + 1) begin
            n_fail++;
            $display("FAIL b2b_write_spacing: got %0d cycles expected %0d", a1 - a0, WR_LAT + 1);
        end

        do_read(26'h1002, lat, data, b);
        c0 = cyc;
        do_read(26'h1003, lat, data, b);
        n_checks++;
        if (cyc - c0 != RD_LAT + 1 || data !== 16'h0304) begin
            n_fail++;
            $display("FAIL b2b_read: spacing=%0d dout=%h expected spacing=%0d dout=0304",
                     cyc - c0, data, RD_LAT + 1);
        end
    endtask

    task automatic test_busy_violation();
        int          acc, lat;
        logic [15:0] data;
        logic        b, dr_seen;

        wait_idle("busy_violation");
        n_checks++;
        if (cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clean_before_violation: cmd_err=%b expected 0", cmd_err);
        end
        issue_write(26'h3000, 16'h1111, acc);
        addr = 26'h1000;
        rd   = 1'b1;
        tick();
        rd = 1'b0;
        n_checks++;
        if (cmd_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_rd_while_busy: cmd_err=%b expected 1", cmd_err);
        end
        dr_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            dr_seen |= data_ready;
        end
        n_checks++;
        if (dr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_rd_no_data: data_ready seen=%b expected 0", dr_seen);
        end
        do_read(26'h3000, lat, data, b);
        n_checks++;
        if (lat != RD_LAT || data !== 16'h1111) begin
            n_fail++;
            $display("FAIL write_under_violation: lat=%0d dout=%h expected %0d 1111",
                     lat, data, RD_LAT);
        end
    endtask

    task automatic test_multi_req();
        int          lat;
        logic [15:0] data;
        logic        b, dr_seen;

        wait_idle("multi_req");
        addr = 26'h2000;
        din  = 16'hcafe;
        rd   = 1'b1;
        wr   = 1'b1;
        tick();
        rd = 1'b0;
        wr = 1'b0;
        tick();
        tick();
        // A write-length busy window shows the write won.
        n_checks++;
        if (busy !== 1'b0 || cmd_err !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_req_write_wins: busy=%b err=%b at E%0d expected 0 1",
                     busy, cmd_err, WR_LAT);
        end
        dr_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            dr_seen |= data_ready;
        end
        n_checks++;
        if (dr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_req_no_read: data_ready seen=%b expected 0", dr_seen);
        end
        do_read(26'h2000, lat, data, b);
        n_checks++;
        if (lat != RD_LAT || data !== 16'hcafe) begin
            n_fail++;
            $display("FAIL multi_req_readback: lat=%0d dout=%h expected %0d cafe",
                     lat, data, RD_LAT);
        end
    endtask

    task automatic test_refresh();
        int          high, lat;
        logic [15:0] data;
        logic        b, dr_seen;

        wait_idle("refresh");
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        high    = (busy === 1'b1) ? 1 : 0;
        dr_seen = data_ready;
        for (int e = 1; e <= REF_CYCLES; e++) begin
            tick();
            if (busy === 1'b1) high++;
            dr_seen |= data_ready;
        end
        n_checks++;
        if (high != REF_CYCLES || busy !== 1'b0 || dr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL refresh_window: busy_cycles=%0d busy_end=%b dr_seen=%b expected %0d 0 0",
                     high, busy, dr_seen, REF_CYCLES);
        end
        do_read(26'h1001, lat, data, b);
        n_checks++;
        if (lat != RD_LAT || data !== 16'h5678) begin
            n_fail++;
            $display("FAIL read_after_refresh: lat=%0d dout=%h expected %0d 5678",
                     lat, data, RD_LAT);
        end
    endtask

    task automatic test_reset_mid_read();
        int          lat;
        logic [15:0] data;
        logic        b, dr_seen;

        wait_idle("reset_mid_read");
        addr = 26'h1001;
        rd   = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        tick();
        tick();
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({busy, data_ready, cmd_err, dout} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL mid_read_reset_values: busy=%b dr=%b err=%b dout=%h expected 1 0 0 0000",
                     busy, data_ready, cmd_err, dout);
        end
        tick();
        tick();
        resetn  = 1'b1;
        dr_seen = 1'b0;
        for (int k = 0; k < INIT_CYCLES + 8; k++) begin
            tick();
            dr_seen |= data_ready;
        end
        n_checks++;
        if (dr_seen !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_read_aborted: dr_seen=%b busy=%b expected 0 0", dr_seen, busy);
        end
        do_read(26'h1000, lat, data, b);
        n_checks++;
        if (lat != RD_LAT || data !== 16'h1234) begin
            n_fail++;
            $display("FAIL read_after_reset: lat=%0d dout=%h expected %0d 1234",
                     lat, data, RD_LAT);
        end
    endtask

    task automatic test_aliasing();
        int          acc, lat;
        logic [15:0] data;
        logic        b;

        issue_write(26'h0001000, 16'hbeef, acc);
        do_read(26'h1001000, lat, data, b);
        n_checks++;
        if (lat != RD_LAT || data !== 16'hbeef) begin
            n_fail++;
            $display("FAIL alias_read: lat=%0d dout=%h expected %0d beef", lat, data, RD_LAT);
        end
        do_read(26'h1001, lat, data, b);
        n_checks++;
        if (lat != RD_LAT || data !== 16'h5678) begin
            n_fail++;
            $display("FAIL alias_neighbour: lat=%0d dout=%h expected %0d 5678",
                     lat, data, RD_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_back_to_back();
        test_busy_violation();
        test_multi_req();
        test_refresh();
        test_reset_mid_read();
        test_aliasing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
